// File: rtl/tristate_bus_arbiter_if.sv
// Bundle of request, data and grant signals shared by the tri-state bus
// arbiter and its requesting channels. The shared bus y itself stays a
// plain net on the arbiter so each channel's tri-state driver resolves
// on a single wire.
interface tristate_bus_arbiter_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] d;
  logic [N-1:0]       gnt;
  logic [OW-1:0]      owner;
  logic               busy;

  // Requesting channels drive req/d and observe the grant.
  modport master (
    output req, d,
    input  gnt, owner, busy
  );

  // The arbiter observes req/d and produces the grant.
  modport slave (
    input  req, d,
    output gnt, owner, busy
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus with N channels.
// One owner at a time, capped hold time while others wait, and a single
// bus-idle TURN cycle between owners so no two drivers ever overlap.
// Optional macro TRISTATE_BUS_KEEPER_EN adds a keeper register that
// drives the last owned value onto y whenever no channel is granted.
module tristate_bus_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  tristate_bus_arbiter_if.slave bus,
  output wire  [WIDTH-1:0]   y
);

  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_TURN = 2'd2;

  localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);

  logic [1:0]    r_state;
  logic [N-1:0]  r_gnt;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_last;
  logic [7:0]    r_hold;

  logic          w_found;
  logic [OW-1:0] w_winner;
  logic [OW:0]   w_sum;
  logic [N-1:0]  w_winner_oh;
  logic          w_own_req;
  logic          w_other;
  logic          w_release;

  // Round-robin search upward from last_owner+1, wrapping at N-1 to 0.
  // The extra bit in w_sum holds last_owner+k before the wrap subtract.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_sum = {1'b0, r_last} + (OW+1)'(k);
      if (w_sum >= (OW+1)'(N)) w_sum = w_sum - (OW+1)'(N);
      if (!w_found && bus.req[w_sum[OW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[OW-1:0];
      end
    end
  end

  assign w_winner_oh = {{(N-1){1'b0}}, 1'b1} << w_winner;

  // While owning, r_gnt is the owner's one-hot, so masking req with it
  // separates the owner's request from everyone else's.
  assign w_own_req = |(bus.req & r_gnt);
  assign w_other   = |(bus.req & ~r_gnt);
  assign w_release = !w_own_req || ((r_hold == HOLD_TOP) && w_other);

  // Arbitration FSM: grant on entry to OWN, clear grant on the edge into TURN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_hold  <= '0;
      r_last  <= OW'(N - 1);
    end else begin
      case (r_state)
        S_IDLE, S_TURN: begin
          if (w_found) begin
            r_state <= S_OWN;
            r_gnt   <= w_winner_oh;
            r_owner <= w_winner;
            r_hold  <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OWN: begin
          if (w_release) begin
            r_state <= S_TURN;
            r_gnt   <= '0;
            r_last  <= r_owner;
          end else if (r_hold != HOLD_TOP) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.owner = r_owner;
  assign bus.busy  = (r_state == S_OWN);

  // One tri-state driver per channel, enabled only by its registered grant.
  for (genvar i = 0; i < N; i++) begin : g_drv
    assign y = r_gnt[i] ? bus.d[i*WIDTH +: WIDTH] : {WIDTH{1'bz}};
  end

`ifdef TRISTATE_BUS_KEEPER_EN
  logic [WIDTH-1:0] r_keep;
  logic [WIDTH-1:0] w_own_data;

  // The value on y during OWN is the granted channel's data; select it
  // directly rather than reading back the resolved bus.
  always_comb begin
    w_own_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_gnt[i]) w_own_data = w_own_data | bus.d[i*WIDTH +: WIDTH];
    end
  end

  // Keeper captures the bus every OWN cycle and holds it while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_keep <= '0;
    else if (r_state == S_OWN) r_keep <= w_own_data;
  end

  assign y = (r_gnt == '0) ? r_keep : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
module tb_tristate_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  wire  [7:0] y;
  int         vectors = 0;
  int         errors  = 0;
  logic [7:0] keep_exp = 8'h00;

  tristate_bus_arbiter_if #(.N(N), .WIDTH(W)) bus ();

  tristate_bus_arbiter #(.N(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .y     (y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit y_idle_ok();
`ifdef TRISTATE_BUS_KEEPER_EN
    return y === keep_exp;
`else
    return $isunknown(y) || (y == 8'h00);
`endif
  endfunction

  // Per-cycle invariants while out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      vectors++;
      if (!$onehot0(bus.gnt)) begin
        errors++;
        $display("FAIL onehot0: gnt=%b required at most one bit set", bus.gnt);
      end
      vectors++;
      if (bus.busy && $isunknown(y)) begin
        errors++;
        $display("FAIL y_known: y=%b required no X/Z while busy", y);
      end
      vectors++;
      if (bus.busy !== (|bus.gnt)) begin
        errors++;
        $display("FAIL busy_vs_gnt: busy=%b gnt=%b", bus.busy, bus.gnt);
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    keep_exp = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    #3;
    vectors++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b busy=%b owner=%0d required 0000/0/0",
               bus.gnt, bus.busy, bus.owner);
    end
    vectors++;
    if (!y_idle_ok()) begin
      errors++;
      $display("FAIL reset_y: y=%h required released", y);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: gnt=%b busy=%b required 0000/0 with clk running",
               bus.gnt, bus.busy);
    end
    do_reset();
  endtask

  task automatic test_single_owner();
    do_reset();
    bus.req = 4'b0001;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.owner !== 2'd0 || y !== 8'hA0) begin
      errors++;
      $display("FAIL single_grant: gnt=%b busy=%b owner=%0d y=%h required 0001/1/0/a0",
               bus.gnt, bus.busy, bus.owner, y);
    end
    keep_exp = 8'hA0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.gnt !== 4'b0001 || y !== 8'hA0) begin
        errors++;
        $display("FAIL single_hold c%0d: gnt=%b y=%h required 0001/a0", c, bus.gnt, y);
      end
    end
    // hold counter is saturated: a newcomer forces release after one edge
    bus.req = 4'b0011;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || !y_idle_ok()) begin
      errors++;
      $display("FAIL saturated_release: gnt=%b busy=%b y=%h required 0000/0/idle",
               bus.gnt, bus.busy, y);
    end
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1 || y !== 8'hA1) begin
      errors++;
      $display("FAIL saturated_next: gnt=%b owner=%0d y=%h required 0010/1/a1",
               bus.gnt, bus.owner, y);
    end
  endtask

  task automatic test_preempt();
    logic [3:0] exp_g [6];
    logic [7:0] exp_y [6];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100};
    exp_y = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'h00, 8'hA2};
    do_reset();
    bus.req = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.gnt !== exp_g[c]) begin
        errors++;
        $display("FAIL preempt_gnt c%0d: gnt=%b required %b", c, bus.gnt, exp_g[c]);
      end
      vectors++;
      if (exp_g[c] != 4'b0000) begin
        if (y !== exp_y[c]) begin
          errors++;
          $display("FAIL preempt_y c%0d: y=%h required %h", c, y, exp_y[c]);
        end
        keep_exp = exp_y[c];
      end else if (!y_idle_ok()) begin
        errors++;
        $display("FAIL preempt_turn_y c%0d: y=%h required released", c, y);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    int         slot;
    int         pos;
    do_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      slot = c / 5;
      pos  = c % 5;
      eg   = (pos == 4) ? 4'b0000 : (4'b0001 << (slot % 4));
      @(negedge clk);
      vectors++;
      if (bus.gnt !== eg) begin
        errors++;
        $display("FAIL rr_gnt c%0d: gnt=%b required %b", c, bus.gnt, eg);
      end
      if (pos != 4) begin
        vectors++;
        if (bus.owner !== 2'(slot % 4) || y !== 8'hA0 + 8'(slot % 4)) begin
          errors++;
          $display("FAIL rr_owner c%0d: owner=%0d y=%h required %0d/%h",
                   c, bus.owner, y, slot % 4, 8'hA0 + 8'(slot % 4));
        end
        keep_exp = 8'hA0 + 8'(slot % 4);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b1000;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b1000 || bus.owner !== 2'd3 || y !== 8'hA3) begin
      errors++;
      $display("FAIL wrap_own3: gnt=%b owner=%0d y=%h required 1000/3/a3",
               bus.gnt, bus.owner, y);
    end
    keep_exp = 8'hA3;
    bus.req = 4'b0001;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_turn: gnt=%b busy=%b required 0000/0", bus.gnt, bus.busy);
    end
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0 || y !== 8'hA0) begin
      errors++;
      $display("FAIL wrap_own0: gnt=%b owner=%0d y=%h required 0001/0/a0",
               bus.gnt, bus.owner, y);
    end
  endtask

  task automatic test_turn_request();
    do_reset();
    bus.req = 4'b0010;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL turnreq_own1: gnt=%b required 0010", bus.gnt);
    end
    keep_exp = 8'hA1;
    bus.req = 4'b0000;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL turnreq_turn: gnt=%b busy=%b required 0000/0", bus.gnt, bus.busy);
    end
    // ch3 request withdrawn before the TURN exit edge must be ignored
    bus.req = 4'b1000;
    #2;
    bus.req = 4'b0100;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2 || y !== 8'hA2) begin
      errors++;
      $display("FAIL turnreq_late: gnt=%b owner=%0d y=%h required 0100/2/a2",
               bus.gnt, bus.owner, y);
    end
    keep_exp = 8'hA2;
    bus.req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || !y_idle_ok()) begin
      errors++;
      $display("FAIL turnreq_idle: gnt=%b busy=%b y=%h required 0000/0/idle",
               bus.gnt, bus.busy, y);
    end
    bus.req = 4'b0001;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0) begin
      errors++;
      $display("FAIL turnreq_from_idle: gnt=%b owner=%0d required 0001/0", bus.gnt, bus.owner);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0100;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0100 || y !== 8'hA2) begin
      errors++;
      $display("FAIL areset_own2: gnt=%b y=%h required 0100/a2", bus.gnt, y);
    end
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    keep_exp = 8'h00;
    #1;
    vectors++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
      errors++;
      $display("FAIL areset_now: gnt=%b busy=%b owner=%0d required 0000/0/0",
               bus.gnt, bus.busy, bus.owner);
    end
    vectors++;
    if (!y_idle_ok()) begin
      errors++;
      $display("FAIL areset_y: y=%h required released", y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2 || y !== 8'hA2) begin
      errors++;
      $display("FAIL areset_first_arb: gnt=%b owner=%0d y=%h required 0100/2/a2",
               bus.gnt, bus.owner, y);
    end
  endtask

  initial begin
    bus.req = '0;
    bus.d   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    test_reset();
    test_single_owner();
    test_preempt();
    test_round_robin();
    test_wrap();
    test_turn_request();
    test_async_reset();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
